// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a shared single-port, fixed-latency memory.
// Serialises instruction fetch and data access and returns registered responses.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush_f,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                last_d_q;
  logic                kill_q;
  logic                op_we_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                if_valid_q;
  logic                d_valid_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;

  logic f_elig;
  logic d_elig;
  logic pick_f;
  logic pick_d;

  // A requester answered this cycle is never re-granted; ties alternate on last_d.
  always_comb begin
    f_elig = if_req & ~flush_f & ~if_valid_q;
    d_elig = (d_rd | d_wr) & ~d_valid_q;
    pick_d = d_elig & (~f_elig | ~last_d_q);
    pick_f = f_elig & ~pick_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_d_q    <= 1'b0;
      kill_q      <= 1'b0;
      op_we_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          kill_q <= 1'b0;
          if (pick_d) begin
            state_q     <= BUSY_D;
            mem_en_q    <= 1'b1;
            mem_we_q    <= d_wr;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            op_we_q     <= d_wr;
            last_d_q    <= 1'b1;
            cnt_q       <= CNT_W'(MEM_LAT);
          end else if (pick_f) begin
            state_q    <= BUSY_I;
            mem_en_q   <= 1'b1;
            mem_addr_q <= if_addr;
            op_we_q    <= 1'b0;
            last_d_q   <= 1'b0;
            cnt_q      <= CNT_W'(MEM_LAT);
          end
        end
        BUSY_I: begin
          if (flush_f) kill_q <= 1'b1;
          // Cancelled fetches still refresh if_rdata but raise no pulse.
          if (cnt_q == '0) begin
            state_q    <= IDLE;
            if_rdata_q <= mem_rdata;
            if_valid_q <= ~(kill_q | flush_f);
            kill_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        BUSY_D: begin
          if (cnt_q == '0) begin
            state_q   <= IDLE;
            d_valid_q <= 1'b1;
            if (!op_we_q) d_rdata_q <= mem_rdata;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign stall_f   = if_req & ~if_valid_q;
  assign stall_m   = (d_rd | d_wr) & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model compared every cycle,
// directed scenarios pinned with literal cycle/data expectations, plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        if_req = 1'b0, flush_f = 1'b0, d_rd = 1'b0, d_wr = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = 16'hDEAD;
  logic        if_valid, d_valid, mem_en, mem_we, stall_f, stall_m;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  logic        reset1 = 1'b0, if_req1 = 1'b0, d_rd1 = 1'b0;
  logic [15:0] if_addr1 = 16'h1000, d_addr1 = 16'h2000, mem_rdata1 = 16'hDEAD;
  logic        if_valid1, d_valid1, mem_en1, mem_we1, stall_f1, stall_m1;
  logic [15:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .flush_f(flush_f),
    .if_valid(if_valid), .if_rdata(if_rdata), .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m));

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset1), .if_req(if_req1), .if_addr(if_addr1), .flush_f(1'b0),
    .if_valid(if_valid1), .if_rdata(if_rdata1), .d_rd(d_rd1), .d_wr(1'b0), .d_addr(d_addr1),
    .d_wdata(16'h0000), .d_valid(d_valid1), .d_rdata(d_rdata1), .mem_en(mem_en1),
    .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .stall_f(stall_f1), .stall_m(stall_m1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory contents: unwritten words read back as addr ^ C3C3.
  logic [15:0] mem_a [int];
  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem_a.exists(int'(a))) return mem_a[int'(a)];
    return a ^ 16'hC3C3;
  endfunction

  logic        hist_en   [16];
  logic [15:0] hist_addr [16];

  // Transaction model state
  logic        e_ifv = 0, e_dv = 0, e_en = 0, e_we = 0;
  logic [15:0] e_ifd = 0, e_dd = 0, e_addr = 0, e_wd = 0;
  bit          op_act = 0, op_d = 0, op_we = 0, op_kill = 0, last_d = 0, model_ok = 0;
  int          op_iss = 0;
  logic [15:0] op_data = 0;

  int          iss_cyc[$];
  logic [15:0] iss_addr[$];
  logic [15:0] iss_wd[$];
  logic        iss_we[$];
  int          ifv_cyc[$];
  logic [15:0] ifv_dat[$];
  int          dv_cyc[$];
  logic [15:0] dv_dat[$];
  int          sf_cnt = 0;
  bit          iv_seen = 0, dv_seen = 0;

  initial forever begin
    bit f_el, d_el, win_d;
    int idx;
    @(negedge clk);
    if (model_ok) begin
      chk("mem_en", 32'(mem_en), 32'(e_en));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
      chk("if_valid", 32'(if_valid), 32'(e_ifv));
      chk("if_rdata", 32'(if_rdata), 32'(e_ifd));
      chk("d_valid", 32'(d_valid), 32'(e_dv));
      chk("d_rdata", 32'(d_rdata), 32'(e_dd));
      chk("stall_f", 32'(stall_f), 32'(if_req & ~e_ifv));
      chk("stall_m", 32'(stall_m), 32'((d_rd | d_wr) & ~e_dv));
    end
    // memory: issue in cycle T returns data during cycle T+LAT
    hist_en[cyc % 16]   = (mem_en === 1'b1);
    hist_addr[cyc % 16] = mem_addr;
    if (mem_en === 1'b1 && mem_we === 1'b1) mem_a[int'(mem_addr)] = mem_wdata;
    idx = (cyc - LAT) % 16;
    mem_rdata = (cyc >= LAT && hist_en[idx]) ? mem_rd(hist_addr[idx]) : 16'hDEAD;
    // model: what the outputs must be next cycle
    if (reset !== 1'b1) begin
      {e_ifv, e_dv, e_en, e_we} = '0;
      {e_ifd, e_dd, e_addr, e_wd} = '0;
      op_act = 0; op_kill = 0; last_d = 0;
    end else begin
      f_el = if_req && !flush_f && !e_ifv;
      d_el = (d_rd || d_wr) && !e_dv;
      e_ifv = 0; e_dv = 0; e_en = 0; e_we = 0; e_wd = '0;
      if (op_act) begin
        if (!op_d && flush_f) op_kill = 1;
        if (cyc == op_iss + LAT) begin
          op_act = 0;
          if (op_d) begin
            e_dv = 1;
            if (!op_we) e_dd = op_data;
          end else begin
            e_ifd = op_data;
            e_ifv = !op_kill;
          end
          op_kill = 0;
        end
      end else if (f_el || d_el) begin
        win_d = d_el && (!f_el || !last_d);
        op_act = 1; op_iss = cyc + 1; op_d = win_d; op_kill = 0; last_d = win_d; e_en = 1;
        if (win_d) begin
          op_we = d_wr; e_we = d_wr; e_addr = d_addr; e_wd = d_wdata;
        end else begin
          op_we = 0; e_addr = if_addr;
        end
        op_data = mem_rd(e_addr);
      end
    end
    model_ok = 1;
    // event log for the directed checks
    if (mem_en === 1'b1) begin
      iss_cyc.push_back(cyc); iss_addr.push_back(mem_addr);
      iss_wd.push_back(mem_wdata); iss_we.push_back(mem_we);
    end
    if (if_valid === 1'b1) begin ifv_cyc.push_back(cyc); ifv_dat.push_back(if_rdata); end
    if (d_valid === 1'b1) begin dv_cyc.push_back(cyc); dv_dat.push_back(d_rdata); end
    if (stall_f === 1'b1) sf_cnt++;
    iv_seen = (if_valid === 1'b1);
    dv_seen = (d_valid === 1'b1);
  end

  // Requests are held until their valid pulse, then dropped the next cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (iv_seen) if_req = 1'b0;
    if (dv_seen) begin d_rd = 1'b0; d_wr = 1'b0; end
  endtask

  task automatic clear_log();
    iss_cyc.delete(); iss_addr.delete(); iss_wd.delete(); iss_we.delete();
    ifv_cyc.delete(); ifv_dat.delete(); dv_cyc.delete(); dv_dat.delete();
    sf_cnt = 0;
  endtask

  // MEM_LAT=1 instance: fetch alone re-grants a cycle late, so loads are interleaved
  // to keep the port busy back to back.
  int  n_ifv1 = 0, n_dv1 = 0, last_iss1 = -1;
  bit  p_en1 = 0, iv1 = 0, dv1 = 0;
  logic [15:0] p_addr1 = '0;

  initial forever begin
    @(negedge clk);
    if (reset1 === 1'b1) begin
      if (mem_en1 === 1'b1) begin
        if (last_iss1 >= 0) chk("lat1_spacing", 32'(cyc - last_iss1), 32'd3);
        last_iss1 = cyc;
      end
      if (if_valid1 === 1'b1) begin
        chk("lat1_if_data", 32'(if_rdata1), 32'(if_addr1 ^ 16'h1234)); n_ifv1++;
      end
      if (d_valid1 === 1'b1) begin
        chk("lat1_d_data", 32'(d_rdata1), 32'(d_addr1 ^ 16'h1234)); n_dv1++;
      end
    end
    mem_rdata1 = p_en1 ? (p_addr1 ^ 16'h1234) : 16'hDEAD;
    p_en1 = (mem_en1 === 1'b1);
    p_addr1 = mem_addr1;
    iv1 = (if_valid1 === 1'b1);
    dv1 = (d_valid1 === 1'b1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset1 = 1'b1; if_req1 = 1'b1; d_rd1 = 1'b1;
    repeat (60) begin
      @(posedge clk); #1;
      if (iv1) if_addr1 = if_addr1 + 16'h1;
      if (dv1) d_addr1 = d_addr1 + 16'h1;
    end
  end

  initial begin
    int t0;
    mem_a[16'h0010] = 16'hA5A5;
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_if_rdata", 32'(if_rdata), 32'd0);
    chk("rst_d_rdata", 32'(d_rdata), 32'd0);

    // fetch alone
    step(); t0 = cyc; clear_log();
    if_req = 1'b1; if_addr = 16'h0010;
    repeat (8) step();
    chk("t1_n_issue", 32'(iss_cyc.size()), 32'd1);
    if (iss_cyc.size() >= 1) begin
      chk("t1_issue_cyc", 32'(iss_cyc[0] - t0), 32'd1);
      chk("t1_issue_addr", 32'(iss_addr[0]), 32'h0010);
    end
    chk("t1_n_ifv", 32'(ifv_cyc.size()), 32'd1);
    if (ifv_cyc.size() >= 1) begin
      chk("t1_ifv_cyc", 32'(ifv_cyc[0] - t0), 32'd4);
      chk("t1_ifv_data", 32'(ifv_dat[0]), 32'hA5A5);
    end
    chk("t1_stall_f_cycles", 32'(sf_cnt), 32'd4);

    // simultaneous fetch + load, last grant was fetch: data first
    step(); t0 = cyc; clear_log();
    if_req = 1'b1; if_addr = 16'h0100; d_rd = 1'b1; d_addr = 16'h0200;
    repeat (11) step();
    chk("t2_n_issue", 32'(iss_cyc.size()), 32'd2);
    if (iss_cyc.size() >= 2) begin
      chk("t2_iss0_cyc", 32'(iss_cyc[0] - t0), 32'd1);
      chk("t2_iss0_addr", 32'(iss_addr[0]), 32'h0200);
      chk("t2_iss1_cyc", 32'(iss_cyc[1] - t0), 32'd5);
      chk("t2_iss1_addr", 32'(iss_addr[1]), 32'h0100);
    end
    if (dv_cyc.size() >= 1 && ifv_cyc.size() >= 1) begin
      chk("t2_dv_cyc", 32'(dv_cyc[0] - t0), 32'd4);
      chk("t2_dv_data", 32'(dv_dat[0]), 32'hC1C3);
      chk("t2_ifv_cyc", 32'(ifv_cyc[0] - t0), 32'd8);
      chk("t2_ifv_data", 32'(ifv_dat[0]), 32'hC2C3);
    end else chk("t2_responses", 32'(dv_cyc.size() + ifv_cyc.size()), 32'd2);

    // store
    step(); t0 = cyc; clear_log();
    d_wr = 1'b1; d_addr = 16'h0033; d_wdata = 16'hBEEF;
    repeat (7) step();
    if (iss_cyc.size() >= 1) begin
      chk("t3_iss_cyc", 32'(iss_cyc[0] - t0), 32'd1);
      chk("t3_iss_we", 32'(iss_we[0]), 32'd1);
      chk("t3_iss_wdata", 32'(iss_wd[0]), 32'hBEEF);
    end else chk("t3_n_issue", 32'(iss_cyc.size()), 32'd1);
    if (dv_cyc.size() >= 1) chk("t3_dv_cyc", 32'(dv_cyc[0] - t0), 32'd4);
    else chk("t3_n_dv", 32'(dv_cyc.size()), 32'd1);
    chk("t3_d_rdata_kept", 32'(d_rdata), 32'hC1C3);

    // both again, last grant was data: fetch first, load reads the stored word
    step(); t0 = cyc; clear_log();
    if_req = 1'b1; if_addr = 16'h0300; d_rd = 1'b1; d_addr = 16'h0033;
    repeat (11) step();
    if (ifv_cyc.size() >= 1 && dv_cyc.size() >= 1) begin
      chk("t3b_ifv_cyc", 32'(ifv_cyc[0] - t0), 32'd4);
      chk("t3b_ifv_data", 32'(ifv_dat[0]), 32'hC0C3);
      chk("t3b_dv_cyc", 32'(dv_cyc[0] - t0), 32'd8);
      chk("t3b_dv_data", 32'(dv_dat[0]), 32'hBEEF);
    end else chk("t3b_responses", 32'(dv_cyc.size() + ifv_cyc.size()), 32'd2);

    // flush during BUSY_I
    step(); t0 = cyc; clear_log();
    if_req = 1'b1; if_addr = 16'h0010;
    step(); step(); flush_f = 1'b1;
    step(); flush_f = 1'b0; if_addr = 16'h0040;
    repeat (7) step();
    chk("t4_n_ifv", 32'(ifv_cyc.size()), 32'd1);
    if (ifv_cyc.size() >= 1) begin
      chk("t4_ifv_cyc", 32'(ifv_cyc[0] - t0), 32'd8);
      chk("t4_ifv_data", 32'(ifv_dat[0]), 32'hC383);
    end
    if (iss_cyc.size() >= 2) begin
      chk("t4_iss1_cyc", 32'(iss_cyc[1] - t0), 32'd5);
      chk("t4_iss1_addr", 32'(iss_addr[1]), 32'h0040);
    end else chk("t4_n_issue", 32'(iss_cyc.size()), 32'd2);

    // flush in IDLE delays the grant by one cycle
    step(); t0 = cyc; clear_log();
    if_req = 1'b1; if_addr = 16'h0050; flush_f = 1'b1;
    step(); flush_f = 1'b0;
    repeat (7) step();
    if (iss_cyc.size() >= 1) chk("t5_iss_cyc", 32'(iss_cyc[0] - t0), 32'd2);
    else chk("t5_n_issue", 32'(iss_cyc.size()), 32'd1);

    // reset during BUSY_D
    step(); t0 = cyc; clear_log();
    d_rd = 1'b1; d_addr = 16'h0077;
    step(); step(); reset = 1'b0; d_rd = 1'b0;
    step(); reset = 1'b1;
    chk("t6_mem_addr", 32'(mem_addr), 32'd0);
    chk("t6_d_rdata", 32'(d_rdata), 32'd0);
    chk("t6_if_rdata", 32'(if_rdata), 32'd0);
    repeat (5) step();
    chk("t6_no_dv", 32'(dv_cyc.size()), 32'd0);
    t0 = cyc; clear_log();
    d_rd = 1'b1; d_addr = 16'h0077;
    repeat (7) step();
    if (dv_cyc.size() >= 1) begin
      chk("t6_dv_cyc", 32'(dv_cyc[0] - t0), 32'd4);
      chk("t6_dv_data", 32'(dv_dat[0]), 32'hC3B4);
    end else chk("t6_n_dv", 32'(dv_cyc.size()), 32'd1);

    repeat (4) step();
    chk("lat1_fetches_seen", 32'(n_ifv1 >= 8), 32'd1);
    chk("lat1_loads_seen", 32'(n_dv1 >= 8), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
